// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    localparam int BE_W   = 4;
    localparam int WORD_W = 32;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } mem_rsp_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the address unit (master) and the memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_W = 32
);
    import data_mem_pkg::*;

    logic              data_req;
    logic              data_gnt;
    logic [ADDR_W-1:0] data_addr;
    logic              data_we;
    logic [BE_W-1:0]   data_be;
    logic [WORD_W-1:0] data_wdata;
    logic              data_rvalid;
    logic [WORD_W-1:0] data_rdata;
    logic              data_err;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );

endinterface

// File: rtl/data_mem_responder_rsp_pipe.sv
// Fixed-latency response delay line; a response entering now leaves LATENCY cycles later.
module rsp_pipe
    import data_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     in_valid_i,
    input  mem_rsp_t in_rsp_i,
    output logic     out_valid_o,
    output mem_rsp_t out_rsp_o
);

    logic [LATENCY-1:0] valid_q, valid_d;
    mem_rsp_t           rsp_q [LATENCY];
    mem_rsp_t           rsp_d [LATENCY];

    always_comb begin
        valid_d[0] = in_valid_i;
        rsp_d[0]   = in_valid_i ? in_rsp_i : '0;
        for (int s = 1; s < LATENCY; s++) begin
            valid_d[s] = valid_q[s-1];
            rsp_d[s]   = rsp_q[s-1];
        end
    end

    // Clearing the pipe drops every in-flight response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) rsp_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < LATENCY; s++) rsp_q[s] <= rsp_d[s];
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_rsp_o   = rsp_q[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Byte-enabled word memory answering data_req with fixed-latency, in-order responses.
// Define DATA_MEM_STALL_EN to add LFSR-driven random grant stalls.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DEPTH_WORDS     = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_mem_responder_if.slave bus
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] widx;
    logic              in_range;
    logic              stall;
    logic              slot_free;
    logic              gnt;
    logic              rsp_valid;
    mem_rsp_t          rsp_in, rsp_out;

    assign idx      = bus.data_addr[ADDR_W-1:2];
    assign widx     = idx[MEM_AW-1:0];
    assign in_range = idx < IDX_W'(DEPTH_WORDS);

`ifdef DATA_MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0] & lfsr_q[1];
`else
    assign stall = 1'b0;
`endif

    // A response leaving this cycle frees its slot for a same-cycle grant.
    always_comb begin
        slot_free = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) || rsp_valid;
        gnt       = bus.data_req && !rst_i && slot_free && !stall;

        rsp_in     = '0;
        rsp_in.err = !in_range;
        if (in_range && !bus.data_we) rsp_in.rdata = mem_q[widx];

        outstanding_d = outstanding_q;
        if (gnt && !rsp_valid)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (!gnt && rsp_valid) outstanding_d = outstanding_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) outstanding_q <= '0;
        else       outstanding_q <= outstanding_d;
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (gnt && bus.data_we && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.data_be[k]) mem_q[widx][8*k +: 8] <= bus.data_wdata[8*k +: 8];
            end
        end
    end

    rsp_pipe #(
        .LATENCY (LATENCY)
    ) u_rsp_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (gnt),
        .in_rsp_i    (rsp_in),
        .out_valid_o (rsp_valid),
        .out_rsp_o   (rsp_out)
    );

    assign bus.data_gnt    = gnt;
    assign bus.data_rvalid = rsp_valid;
    assign bus.data_rdata  = rsp_valid ? rsp_out.rdata : '0;
    assign bus.data_err    = rsp_valid & rsp_out.err;

endmodule
